// File: rtl/fir_tap_mac.sv
// Serial multiply-accumulate over one 10-tap group of the FIR delay line.
// One registered partial sum per 600 kHz sample, using a writable signed coefficient bank.
module fir_tap_mac #(
    parameter int TAPS   = 10,
    parameter int TAP_W  = 3,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 23
) (
    input  logic                     iClk12M,
    input  logic                     iRst,
    input  logic                     iEnSample600k,
    input  logic [TAPS*TAP_W-1:0]    iTaps,
    input  logic                     iCoefWr,
    input  logic [3:0]               iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    output logic signed [ACC_W-1:0]  oMac,
    output logic                     oValid,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int IDX_W  = 4;
    localparam int PROD_W = TAP_W + COEF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] NUM_TAPS = IDX_W'(TAPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic                      en_d1_q;
    logic [TAPS*TAP_W-1:0]     taps_q;
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]          idx_q;
    logic signed [ACC_W-1:0]   mac_q;
    logic                      valid_q;
    logic                      busy_q;
    logic                      overrun_q;

    logic signed [TAP_W-1:0]   tap_sel_s;
    logic signed [COEF_W-1:0]  coef_sel_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;

    // Select the current tap/coefficient pair and form the sign-extended product.
    always_comb begin
        tap_sel_s  = '0;
        coef_sel_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                tap_sel_s  = taps_q[k*TAP_W +: TAP_W];
                coef_sel_s = coef_q[k];
            end else begin
                tap_sel_s  = tap_sel_s;
                coef_sel_s = coef_sel_s;
            end
        end
        prod_s     = PROD_W'(tap_sel_s) * PROD_W'(coef_sel_s);
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end

    // Sequencer, coefficient bank and registered outputs.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            en_d1_q   <= 1'b0;
            taps_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            mac_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            en_d1_q <= iEnSample600k;
            valid_q <= 1'b0;
            // Busy gating uses the registered flag so a write beside the strobe still lands.
            if (iCoefWr && !busy_q && (iCoefAddr < NUM_TAPS)) begin
                coef_q[iCoefAddr] <= iCoefData;
            end
            if (en_d1_q && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (en_d1_q) begin
                        taps_q  <= iTaps;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_MAC;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= iEnSample600k;
                    end
                end
                S_MAC: begin
                    acc_q  <= acc_q + prod_ext_s;
                    idx_q  <= idx_q + 4'd1;
                    busy_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    mac_q   <= acc_q;
                    valid_q <= 1'b1;
                    state_q <= S_IDLE;
                    busy_q  <= iEnSample600k;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oMac     = mac_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_q;
    assign oOverrun = overrun_q;

endmodule

// File: doc/fir_tap_mac.md
Name: fir_tap_mac

Overview:
- Consumer of one 30-bit packed tap group from the FIR delay line: 10 signed 3-bit taps.
- After each 600 kHz sample strobe, snapshots the tap bus and runs a serial multiply-accumulate over the 10 taps against a writable 16-bit signed coefficient bank.
- Emits one registered partial sum per sample.
- Four instances, one per tap group, feed the filter's final adder.
- 12 MHz clock gives a 20-clock sample budget; the block needs 11.

Parameters:
- TAPS, 10, taps per group / coefficient bank depth.
- TAP_W, 3, signed tap width.
- COEF_W, 16, signed coefficient width.
- ACC_W, 23, accumulator/output width = TAP_W + COEF_W + 4.

Ports:
- iClk12M  input  1  12 MHz system clock.
- iRst  input  1  reset, synchronous, active-high.
- iEnSample600k  input  1  one-cycle sample strobe, the same strobe that shifts the delay line.
- iTaps  input  TAPS*TAP_W (30)  packed taps; tap k = iTaps[3k+2:3k]; tap 0 is the newest sample.
- iCoefWr  input  1  coefficient write enable.
- iCoefAddr  input  4  coefficient index 0..9.
- iCoefData  input  COEF_W  signed coefficient value.
- oMac  output  ACC_W  signed sum of tap[k]*coef[k], k=0..9.
- oValid  output  1  one-cycle pulse when oMac updates.
- oBusy  output  1  high while the state is not IDLE.
- oOverrun  output  1  sticky flag: a strobe arrived while busy.

Behaviour:
- Reset is synchronous and active-high. It forces:
  - state=IDLE.
  - all 10 coefficients=0.
  - oMac=0, oValid=0, oBusy=0, oOverrun=0.
  - internal accumulator, index and strobe delay register=0.
- Reset mid-operation aborts the current MAC. No oValid is issued for the aborted sample.
- Strobe alignment:
  - The delay line updates its taps on the edge that samples iEnSample600k=1.
  - The block therefore registers the strobe (rEnD1) and snapshots iTaps one edge later, when the bus holds the new sample.
- FSM states are IDLE, MAC and DONE.
  - IDLE: when rEnD1=1, snapshot iTaps into a 30-bit register, clear acc, idx=0, go to MAC.
  - MAC: acc <= acc + sext(tap[idx]) * sext(coef[idx]), idx++. After the idx=9 accumulate, go to DONE.
  - DONE: oMac <= acc, oValid=1 for one cycle, return to IDLE.
- Latency, counting from edge E0 that samples the strobe:
  - E1: snapshot.
  - E2..E11: 10 accumulates.
  - E12: oMac loads and oValid is high for the following cycle.
  - Next strobe may be sampled at E13 or later.
- Arithmetic:
  - Full-precision two's complement; no saturation or rounding.
  - Product width is 19 bits, sign-extended to ACC_W before accumulation.
  - Worst-case |sum| = 10*4*32768 = 1,310,720, which fits in 23 bits signed.
- oMac holds its value between oValid pulses.
- oBusy=1 in MAC and DONE, and also on the E1 cycle once rEnD1 is set.
- Overrun:
  - rEnD1=1 while state != IDLE sets oOverrun, which stays set until reset.
  - The strobe is dropped; the current computation continues unaffected.
- Coefficient writes:
  - A write with iCoefWr=1 and iCoefAddr<10 while oBusy=0 updates coef[iCoefAddr] at the edge.
  - A write while oBusy=1 is ignored; the coefficient is unchanged.
  - A write with iCoefAddr>=10 is ignored.
  - A write and a strobe in the same IDLE cycle: the write lands, and the MAC that follows uses the new value.
- Ports not listed as outputs carry no combinational path to outputs; all outputs are registered.

Test Plan:
- Reset then idle: hold iRst for 2 clocks, release, no strobe for 40 clocks -> oMac=0, oValid=0, oBusy=0, oOverrun=0 throughout.
- Single-tap impulse:
  - Stimulus: coef[k]=k+1; iTaps with tap0=+1, others 0; strobe at E0.
  - Response: oValid pulses exactly once, after E12; oMac=1.
  - Repeat with tap9=-1 -> oMac=-10.
- Extreme values: all coef=-32768, all taps=-4 -> oMac=+1,310,720. All coef=+32767, all taps=-4 -> oMac=-1,310,680. No wrap in either case.
- Tap-bus timing:
  - Stimulus: change iTaps from all-0 to all-+1 on the cycle after the strobe edge; all coef=1.
  - Response: oMac=10, proving the snapshot is taken at E1, not E0.
- Overrun and write lockout:
  - Stimulus: strobe at E0 and again at E5; write coef[0]=100 at E6.
  - Response: exactly one oValid; oOverrun=1 from E6 onward; coef[0] keeps its old value.
  - A later strobe while idle confirms the unchanged coefficient.
- Reset mid-MAC: assert iRst at E6 for 1 clock -> no oValid, oMac=0, oBusy=0, coefficients=0. The next strobe produces oMac=0.
